// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer for the 4-bit processor: fetches 16-bit instructions
// over a req/ack handshake and drives the external ALU and register file.
module instr_sequencer #(
    parameter int unsigned PC_W = 8
) (
    input  logic            Clk,
    input  logic            Rst_N,
    input  logic            Run,
    output logic            Imem_Req,
    output logic [PC_W-1:0] Imem_Addr,
    input  logic            Imem_Ack,
    input  logic [15:0]     Imem_Data,
    output logic [3:0]      Alu_Opcode,
    input  logic [3:0]      Alu_Result,
    input  logic            Alu_Carry,
    input  logic            Alu_Zero,
    input  logic            Alu_Sign,
    output logic [2:0]      Reg_Addr_A,
    output logic [2:0]      Reg_Addr_B,
    output logic            Wr_En,
    output logic [3:0]      D_In,
    output logic            Flag_C,
    output logic            Flag_Z,
    output logic            Flag_S,
    output logic            Halted,
    output logic [PC_W-1:0] Pc
);

    localparam int unsigned IW   = 16;
    localparam int unsigned OP_W = 4;
    localparam int unsigned RA_W = 3;
    localparam int unsigned DW   = 4;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_WB     = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    localparam logic [OP_W-1:0] OP_LDI = 4'hC;
    localparam logic [OP_W-1:0] OP_JMP = 4'hD;
    localparam logic [OP_W-1:0] OP_JZ  = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic            req_q, req_d;
    logic [OP_W-1:0] alu_op_q, alu_op_d;
    logic [RA_W-1:0] addr_a_q, addr_a_d;
    logic [RA_W-1:0] addr_b_q, addr_b_d;
    logic            wr_en_q, wr_en_d;
    logic [DW-1:0]   d_in_q, d_in_d;
    logic            flag_c_q, flag_c_d;
    logic            flag_z_q, flag_z_d;
    logic            flag_s_q, flag_s_d;
    logic            halted_q, halted_d;

    logic [OP_W-1:0] ir_op;
    logic [RA_W-1:0] ir_rd;
    logic [RA_W-1:0] ir_rs;
    logic [DW-1:0]   ir_imm;
    logic [PC_W-1:0] ir_target;

    assign ir_op     = ir_q[15:12];
    assign ir_rd     = ir_q[11:9];
    assign ir_rs     = ir_q[8:6];
    assign ir_imm    = ir_q[3:0];
    assign ir_target = PC_W'(ir_q[7:0]);

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q  <= S_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            req_q    <= 1'b0;
            alu_op_q <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            wr_en_q  <= 1'b0;
            d_in_q   <= '0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_s_q <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            req_q    <= req_d;
            alu_op_q <= alu_op_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            wr_en_q  <= wr_en_d;
            d_in_q   <= d_in_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            flag_s_q <= flag_s_d;
            halted_q <= halted_d;
        end
    end

    // Outputs are computed one state ahead so they are valid during the state that owns them.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        req_d    = req_q;
        alu_op_d = alu_op_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        wr_en_d  = 1'b0;
        d_in_d   = d_in_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        flag_s_d = flag_s_q;
        halted_d = halted_q;

        case (state_q)
            S_FETCH: begin
                if (!req_q) begin
                    if (Run) begin
                        req_d = 1'b1;
                    end
                end else if (Imem_Ack) begin
                    ir_d    = Imem_Data;
                    pc_d    = pc_q + PC_W'(1);
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ir_op)
                    OP_LDI: begin
                        wr_en_d  = 1'b1;
                        d_in_d   = ir_imm;
                        addr_a_d = ir_rd;
                        addr_b_d = ir_rd;
                        state_d  = S_WB;
                    end
                    OP_JMP: begin
                        pc_d    = ir_target;
                        state_d = S_FETCH;
                    end
                    OP_JZ: begin
                        if (flag_z_q) begin
                            pc_d = ir_target;
                        end
                        state_d = S_FETCH;
                    end
                    OP_HLT: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    default: begin
                        alu_op_d = ir_op;
                        addr_a_d = ir_rd;
                        addr_b_d = ir_rs;
                        state_d  = S_EXEC;
                    end
                endcase
            end
            S_EXEC: begin
                // Both write ports must target Rd during write-back.
                d_in_d   = Alu_Result;
                flag_c_d = Alu_Carry;
                flag_z_d = Alu_Zero;
                flag_s_d = Alu_Sign;
                wr_en_d  = 1'b1;
                addr_a_d = ir_rd;
                addr_b_d = ir_rd;
                state_d  = S_WB;
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign Imem_Req   = req_q;
    assign Imem_Addr  = pc_q;
    assign Pc         = pc_q;
    assign Alu_Opcode = alu_op_q;
    assign Reg_Addr_A = addr_a_q;
    assign Reg_Addr_B = addr_b_q;
    assign Wr_En      = wr_en_q;
    assign D_In       = d_in_q;
    assign Flag_C     = flag_c_q;
    assign Flag_Z     = flag_z_q;
    assign Flag_S     = flag_s_q;
    assign Halted     = halted_q;

endmodule
